// File: rtl/add_share_pkg.sv
// ----------------------------------------------------------------------------
// add_share_pkg
// Shared definitions for the shared-adder arbiter (add_share_arb) and its
// round-robin picker (rr_pick).
//   WIDTH_DEF / NREQ_DEF : default operand width and requester count
//   id_width()           : width of a requester tag / round-robin pointer
//   s1_entry_t           : operand stage entry {in0, in1, id}
//   s2_entry_t           : result stage entry {sum, id, [carry]}
// The entry typedefs describe the default configuration. add_share_arb
// declares the same layouts sized by its own parameters.
// Optional feature macro: ADD_SHARE_ARB_CARRY_EN (adds carry to s2_entry_t).
// ----------------------------------------------------------------------------
package add_share_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREQ_DEF  = 4;

    // A single requester still needs a one-bit tag.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEF = id_width(NREQ_DEF);

    typedef struct packed {
        logic [WIDTH_DEF-1:0] in0;
        logic [WIDTH_DEF-1:0] in1;
        logic [IDW_DEF-1:0]   id;
    } s1_entry_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] sum;
        logic [IDW_DEF-1:0]   id;
`ifdef ADD_SHARE_ARB_CARRY_EN
        logic                 carry;
`endif
    } s2_entry_t;

endpackage

// File: rtl/add_share_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward starting at
// rr_ptr+1, wrapping from NREQ-1 to 0, and returns the first set index.
//   req       : request vector
//   rr_ptr    : index of the most recently served requester
//   grant     : chosen index (0 when nothing is requesting)
//   any_valid : at least one request is set
// ----------------------------------------------------------------------------
module rr_pick
    import add_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_valid
);

    // Walk from the farthest candidate back to the nearest so the nearest
    // requesting index is the last (winning) assignment.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                grant     = IDW'((int'(rr_ptr) + k) % NREQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// ----------------------------------------------------------------------------
// add_share_arb
// Shares one registered adder between NREQ requesters. A round-robin pick
// loads the winner's operands into S1; S1's sum is registered into S2,
// which drives the tagged response channel directly.
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset, discards in-flight entries
//   req_valid   : per-requester operand valid
//   req_ready   : per-requester accept, one-hot or zero
//   req_in0/1   : packed operands, slice i belongs to requester i
//   resp_valid  : result valid
//   resp_ready  : consumer accepts the result
//   resp_id     : requester that owns the result
//   resp_sum    : in0 + in1 modulo 2^WIDTH
//   busy        : either pipeline stage holds an entry
//   resp_carry  : carry out of the sum (only with ADD_SHARE_ARB_CARRY_EN)
// Optional feature macro: ADD_SHARE_ARB_CARRY_EN.
// ----------------------------------------------------------------------------
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_in0,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  busy
`ifdef ADD_SHARE_ARB_CARRY_EN
    ,
    output logic                  resp_carry
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] in0;
        logic [WIDTH-1:0] in1;
        logic [IDW-1:0]   id;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [IDW-1:0]   id;
`ifdef ADD_SHARE_ARB_CARRY_EN
        logic             carry;
`endif
    } s2_t;

    s1_t              s1;
    s2_t              s2;
    s2_t              s2_next;
    logic             s1_valid;
    logic             s2_valid;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic             s2_free;
    logic             s1_free;
    logic             accept;
    logic             s2_load;
    logic [WIDTH-1:0] sel_in0;
    logic [WIDTH-1:0] sel_in1;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign s2_free = !s2_valid || resp_ready;
    assign s1_free = !s1_valid || s2_free;
    assign s2_load = s1_valid && s2_free;

    // Gating with reset_n keeps req_ready low while reset is held, even if
    // clients are already presenting requests.
    assign accept    = any_valid && s1_free && reset_n;
    assign req_ready = accept ? (NREQ'(1) << grant) : '0;

    always_comb begin
        sel_in0 = '0;
        sel_in1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_in0 = req_in0[i*WIDTH +: WIDTH];
                sel_in1 = req_in1[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        s2_next    = '0;
        s2_next.id = s1.id;
`ifdef ADD_SHARE_ARB_CARRY_EN
        {s2_next.carry, s2_next.sum} = {1'b0, s1.in0} + {1'b0, s1.in1};
`else
        s2_next.sum = s1.in0 + s1.in1;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            rr_ptr   <= IDW'(NREQ - 1);
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1.in0   <= sel_in0;
            s1.in1   <= sel_in1;
            s1.id    <= grant;
            rr_ptr   <= grant;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2       <= s2_next;
        end else if (resp_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign resp_valid = s2_valid;
    assign resp_id    = s2.id;
    assign resp_sum   = s2.sum;
    assign busy       = s1_valid || s2_valid;
`ifdef ADD_SHARE_ARB_CARRY_EN
    assign resp_carry = s2.carry;
`endif

endmodule
